// File: rtl/key_arbiter.sv
// key_arbiter: latches debounced key pulses as pending requests and serialises them into a
// valid/ready command stream with a hold-off gap. Define KEY_ARB_RR_EN for round-robin, else fixed priority.
module key_arbiter #(
  parameter int N_KEY  = 4,
  parameter int ID_W   = 2,
  parameter int GAP    = 2,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEY-1:0]  key_pulse,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic [ID_W-1:0]   cmd_id,
  output logic [N_KEY-1:0]  pend,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int CW = $clog2(N_KEY + 1);

  typedef enum logic [1:0] {IDLE, OFFER, HOLD} state_t;

  state_t             state;
  logic [7:0]         gap_cnt;
  logic [ID_W-1:0]    winner;
  logic               grant_en;
  logic [N_KEY-1:0]   grant_vec;
  logic [N_KEY-1:0]   drop_hits;
  logic [CW-1:0]      hit_count;
  logic [DROP_W+CW-1:0] drop_sum;
  logic [DROP_W-1:0]  drop_next;

`ifdef KEY_ARB_RR_EN
  logic [ID_W-1:0] ptr;
  logic            rr_found;

  // Scan pend starting at the pointer, wrapping at the last real key.
  always_comb begin
    winner   = '0;
    rr_found = 1'b0;
    for (int k = 0; k < N_KEY; k++) begin
      if (!rr_found && pend[(int'(ptr) + k) % N_KEY]) begin
        winner   = ID_W'((int'(ptr) + k) % N_KEY);
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      ptr <= '0;
    else if (grant_en)
      ptr <= (winner == ID_W'(N_KEY - 1)) ? '0 : winner + ID_W'(1);
  end
`else
  always_comb begin
    winner = '0;
    for (int i = N_KEY - 1; i >= 0; i--)
      if (pend[i]) winner = ID_W'(i);
  end
`endif

  assign grant_en  = (state == IDLE) && (|pend);
  assign grant_vec = grant_en ? (N_KEY'(1) << winner) : '0;
  assign drop_hits = key_pulse & pend & ~grant_vec;

  always_comb begin
    hit_count = '0;
    for (int i = 0; i < N_KEY; i++)
      hit_count = hit_count + CW'(drop_hits[i]);
  end

  // Wide sum so several coalesced presses in one cycle saturate cleanly.
  assign drop_sum  = {{CW{1'b0}}, drop_cnt} + {{DROP_W{1'b0}}, hit_count};
  assign drop_next = (|drop_sum[DROP_W+CW-1:DROP_W]) ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend     <= '0;
      drop_cnt <= '0;
    end else begin
      pend     <= key_pulse | (pend & ~grant_vec);
      drop_cnt <= drop_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      cmd_id    <= '0;
      busy      <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_en) begin
            cmd_id    <= winner;
            cmd_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            gap_cnt   <= 8'(GAP);
            busy      <= (GAP != 0);
            state     <= (GAP != 0) ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (gap_cnt == 8'd1) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: begin
          cmd_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_arbiter.sv
// tb_key_arbiter: directed and randomized stimulus checked cycle by cycle against a
// behavioural model of the arbiter; a second DROP_W=2 instance exercises counter saturation.
module tb_key_arbiter;

  localparam int N_KEY  = 4;
  localparam int ID_W   = 2;
  localparam int GAP    = 2;
  localparam int DROP_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_KEY-1:0] key_pulse;
  logic             cmd_ready;

  logic              cmd_valid, busy;
  logic [ID_W-1:0]   cmd_id;
  logic [N_KEY-1:0]  pend;
  logic [DROP_W-1:0] drop_cnt;

  logic              s_cmd_valid, s_busy;
  logic [ID_W-1:0]   s_cmd_id;
  logic [N_KEY-1:0]  s_pend;
  logic [1:0]        s_drop_cnt;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit m_pend[N_KEY];
  bit m_valid;
  int m_id;
  int m_hold;
  int m_drops;
  int m_ptr;

  always #5 clk = ~clk;

  key_arbiter #(.N_KEY(N_KEY), .ID_W(ID_W), .GAP(GAP), .DROP_W(DROP_W)) u_dut (
    .clk(clk), .rst(rst), .key_pulse(key_pulse), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_id(cmd_id), .pend(pend), .busy(busy), .drop_cnt(drop_cnt)
  );

  key_arbiter #(.N_KEY(N_KEY), .ID_W(ID_W), .GAP(GAP), .DROP_W(2)) u_dut_small (
    .clk(clk), .rst(rst), .key_pulse(key_pulse), .cmd_ready(cmd_ready),
    .cmd_valid(s_cmd_valid), .cmd_id(s_cmd_id), .pend(s_pend), .busy(s_busy), .drop_cnt(s_drop_cnt)
  );

  function automatic int pendValue();
    int v = 0;
    for (int i = 0; i < N_KEY; i++)
      if (m_pend[i]) v += (1 << i);
    return v;
  endfunction

  function automatic int satDrops(input int limit);
    return (m_drops > limit) ? limit : m_drops;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock of the reference arbiter, from the rules: pick a winner when idle,
  // latch/coalesce presses, run the handshake and the hold-off gap.
  task automatic modelStep(input logic r, input logic [N_KEY-1:0] k, input logic rdy);
    int grant = -1;
    if (!r) begin
      for (int i = 0; i < N_KEY; i++) m_pend[i] = 0;
      m_valid = 0; m_id = 0; m_hold = 0; m_drops = 0; m_ptr = 0;
      return;
    end
    if (!m_valid && m_hold == 0) begin
`ifdef KEY_ARB_RR_EN
      for (int s = 0; s < N_KEY; s++)
        if (grant < 0 && m_pend[(m_ptr + s) % N_KEY]) grant = (m_ptr + s) % N_KEY;
`else
      for (int i = 0; i < N_KEY; i++)
        if (grant < 0 && m_pend[i]) grant = i;
`endif
    end
    for (int i = 0; i < N_KEY; i++) begin
      if (k[i] && m_pend[i] && i != grant) m_drops++;
      m_pend[i] = k[i] || (m_pend[i] && i != grant);
    end
    if (m_valid && rdy) begin
      m_valid = 0;
      m_hold  = GAP;
    end else if (m_hold > 0) begin
      m_hold--;
    end
    if (grant >= 0) begin
      m_valid = 1;
      m_id    = grant;
      m_ptr   = (grant + 1) % N_KEY;
    end
  endtask

  task automatic compareAll();
    checkOutput("cmd_valid", 32'(cmd_valid), 32'(m_valid));
    checkOutput("cmd_id", 32'(cmd_id), 32'(m_id));
    checkOutput("pend", 32'(pend), 32'(pendValue()));
    checkOutput("busy", 32'(busy), 32'(m_valid || m_hold > 0));
    checkOutput("drop_cnt", 32'(drop_cnt), 32'(satDrops(255)));
    checkOutput("drop_cnt_w2", 32'(s_drop_cnt), 32'(satDrops(3)));
  endtask

  task automatic applyStimulus(input logic r, input logic [N_KEY-1:0] k, input logic rdy);
    @(negedge clk);
    rst = r; key_pulse = k; cmd_ready = rdy;
    @(posedge clk);
    modelStep(r, k, rdy);
    #1;
    compareAll();
  endtask

  initial begin
    logic [DROP_W-1:0] drops_before;
    rst = 1'b0; key_pulse = '0; cmd_ready = 1'b0;

    // Reset with all keys pressed
    applyStimulus(1'b0, 4'b1111, 1'b0);
    applyStimulus(1'b0, 4'b1111, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    checkOutput("reset_pend", 32'(pend), 32'd0);
    checkOutput("reset_valid", 32'(cmd_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_drop", 32'(drop_cnt), 32'd0);

    // Single press of key 2
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'b0000, 1'b1);
    applyStimulus(1'b1, 4'b0100, 1'b1);
    checkOutput("single_pend", 32'(pend), 32'b0100);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    checkOutput("single_valid", 32'(cmd_valid), 32'd1);
    checkOutput("single_id", 32'(cmd_id), 32'd2);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    checkOutput("single_valid_drop", 32'(cmd_valid), 32'd0);
    checkOutput("single_busy_hold", 32'(busy), 32'd1);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    checkOutput("single_busy_hold2", 32'(busy), 32'd1);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    checkOutput("single_idle", 32'(busy), 32'd0);

    // Simultaneous presses, two rounds, then presses landing in HOLD
    for (int round = 0; round < 2; round++) begin
      applyStimulus(1'b1, 4'b1011, 1'b1);
      for (int i = 0; i < 14; i++) applyStimulus(1'b1, 4'b0000, 1'b1);
    end
    applyStimulus(1'b1, 4'b0100, 1'b1);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    applyStimulus(1'b1, 4'b1000, 1'b1);
    applyStimulus(1'b1, 4'b0001, 1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 4'b0000, 1'b1);

    // Fairness: keys 0 and 1 kept pending continuously
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 4'b0011, 1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 4'b0000, 1'b1);

    // Backpressure and coalescing from a fresh reset
    applyStimulus(1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b0001, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'b1000, 1'b0);
      checkOutput("bp_id_stable", 32'(cmd_id), 32'd0);
    end
    checkOutput("bp_drop4", 32'(drop_cnt), 32'd4);
    applyStimulus(1'b1, 4'b1000, 1'b0);
    applyStimulus(1'b1, 4'b1000, 1'b0);
    checkOutput("bp_drop6", 32'(drop_cnt), 32'd6);
    checkOutput("bp_drop_sat", 32'(s_drop_cnt), 32'd3);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 4'b0000, 1'b1);

    // Set wins over grant-clear, then reset during OFFER
    drops_before = drop_cnt;
    applyStimulus(1'b1, 4'b0010, 1'b0);
    applyStimulus(1'b1, 4'b0010, 1'b0);
    checkOutput("setwin_valid", 32'(cmd_valid), 32'd1);
    checkOutput("setwin_id", 32'(cmd_id), 32'd1);
    checkOutput("setwin_pend1", 32'(pend[1]), 32'd1);
    checkOutput("setwin_drop", 32'(drop_cnt), 32'(drops_before));
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("rst_offer_valid", 32'(cmd_valid), 32'd0);
    checkOutput("rst_offer_pend", 32'(pend), 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++)
      applyStimulus(($urandom_range(0, 199) != 0), N_KEY'($urandom & $urandom),
                    ($urandom_range(0, 3) != 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
